// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT products per batch with overflow, drop and clear tracking
module product_accumulator #(
    parameter int N     = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = 2 * N + 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [2*N-1:0]             in_product,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ack,
    output logic [ACC_W-1:0]           sum,
    output logic                       overflow,
    output logic                       dropped,
    output logic [$clog2(COUNT+1)-1:0] count,
    output logic                       busy
);

    localparam int CW = $clog2(COUNT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] COUNT_MAX = CW'(COUNT);
    localparam logic [CW-1:0] COUNT_ONE = CW'(1);
    // A single-product batch is complete as soon as it starts.
    localparam logic [1:0] S_START = (COUNT == 1) ? S_DONE : S_ACCUM;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             dropped_q, dropped_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W:0]   add_full;

    assign prod_ext = ACC_W'(in_product);
    assign add_full = {1'b0, sum_q} + {1'b0, prod_ext};

    always_comb begin
        state_d    = state_q;
        sum_d      = sum_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sum_d      = prod_ext;
                    count_d    = COUNT_ONE;
                    overflow_d = 1'b0;
                    state_d    = S_START;
                end
            end
            S_ACCUM: begin
                if (in_valid) begin
                    sum_d      = add_full[ACC_W-1:0];
                    overflow_d = overflow_q | add_full[ACC_W];
                    count_d    = count_q + COUNT_ONE;
                    if (count_d == COUNT_MAX) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ack) begin
                    overflow_d = 1'b0;
                    if (in_valid) begin
                        // Ack and the next product coincide: roll straight into a new batch.
                        sum_d   = prod_ext;
                        count_d = COUNT_ONE;
                        state_d = S_START;
                    end else begin
                        count_d = '0;
                        state_d = S_IDLE;
                    end
                end else if (in_valid) begin
                    dropped_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (clear) begin
            state_d    = S_IDLE;
            sum_d      = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            dropped_d  = 1'b0;
        end

        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            dropped_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            dropped_q   <= dropped_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;
    assign busy      = busy_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N, 4, multiplier operand width; the product input is 2*N bits.
- COUNT, 4, number of products summed per batch (COUNT >= 1).
- ACC_W, 2*N+2, accumulator and sum width (ACC_W >= 2*N).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  one-cycle pulse, driven by the upstream multiplier's ready output.
- in_product  in  2*N  product word, sampled when in_valid=1.
- clear  in  1  synchronous batch abort.
- out_valid  out  1  batch sum available.
- out_ack  in  1  consumer accepts the sum.
- sum  out  ACC_W  running or final accumulated value.
- overflow  out  1  a carry was lost during the current batch.
- dropped  out  1  a product was discarded while in DONE.
- count  out  clog2(COUNT+1)  number of products accepted in the current batch.
- busy  out  1  high in ACCUM or DONE.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low, sampled on the clk rising edge via rst_n.

Function
REQ-004 The FSM SHALL have three states, IDLE, ACCUM and DONE, and all outputs SHALL be registered.
REQ-005 In IDLE, in_valid=1 SHALL load sum<=zero-extended in_product and count<=1, and SHALL go to ACCUM (or to DONE if COUNT==1).
REQ-006 In ACCUM, in_valid=1 SHALL do sum<=sum+in_product modulo 2^ACC_W and count<=count+1.
REQ-007 In ACCUM, when count reaches COUNT, the next state SHALL be DONE.
REQ-008 out_valid SHALL be 1 exactly while in DONE, which is the cycle after the COUNT-th in_valid is sampled.
REQ-009 overflow SHALL be set when an addition carries out of bit ACC_W-1.
REQ-010 overflow SHALL stay set until the next batch starts, clear, or reset, and SHALL be valid alongside out_valid.
REQ-011 In DONE, sum, count and overflow SHALL hold until out_ack=1.
REQ-012 out_ack=1 in DONE with in_valid=0 SHALL go to IDLE; sum SHALL hold its value, count<=0 and overflow<=0.
REQ-013 out_ack=1 in DONE with in_valid=1 in the same cycle SHALL start a new batch.
- sum<=in_product, count<=1, overflow<=0.
- Next state ACCUM (or DONE if COUNT==1).
- No product is lost.
REQ-014 in_valid=1 in DONE without out_ack SHALL discard the product and set dropped.
- dropped SHALL be sticky until clear or reset.
REQ-015 out_ack outside DONE SHALL be ignored.
REQ-016 clear=1 SHALL force IDLE with sum=0, count=0, overflow=0 and dropped=0.
- clear SHALL take priority over in_valid and out_ack in the same cycle.
REQ-017 busy SHALL be 1 in ACCUM and DONE, and 0 in IDLE.
REQ-018 Throughput SHALL be one product per cycle; back-to-back in_valid pulses SHALL all be accepted in IDLE and ACCUM.

Reset
REQ-019 rst_n=0 SHALL force IDLE, sum=0, count=0, out_valid=0, overflow=0, dropped=0 and busy=0.
- Reset SHALL take priority over clear and all other inputs.
REQ-020 Reset asserted mid-batch (ACCUM or DONE) SHALL abandon the partial sum.
- The first in_valid after reset release SHALL begin a fresh batch with count=1.

Verification
REQ-021 Basic batch (N=4, COUNT=4): products 15, 30, 45, 60 on consecutive cycles -> next cycle out_valid=1, sum=150, count=4, overflow=0.
REQ-022 Ack plus new product: in DONE with sum=150, out_ack=1 and in_valid=1 with product 7 in the same cycle -> next cycle out_valid=0, ACCUM, sum=7, count=1.
REQ-023 Overflow (ACC_W=8, COUNT=2): products 225, 225 -> out_valid=1, sum=194, overflow=1.
- After out_ack, the next batch starts with overflow=0.
REQ-024 Drop: in DONE, in_valid with product 9 and no ack -> sum unchanged, dropped=1, out_valid stays 1.
- A following clear -> dropped=0, IDLE, sum=0.
REQ-025 Clear vs input: clear=1 and in_valid=1 (product 12) in the same ACCUM cycle -> IDLE, sum=0, count=0.
REQ-026 Reset mid-batch: two products accepted, then rst_n=0 for 1 cycle -> all outputs at reset values.
- Next product 5 -> sum=5, count=1.
